hpi_txn_sequencer: RTL and testbench

- Hardware master that turns single-word HPI read/write requests into correctly timed chip-select, read and write strobe sequences.
- Sits directly upstream of the HPI I/O interface stage and drives its software-side port (address, data out, active-low r/w/cs), so fabric logic can talk to the CY7C67200 without a CPU.
- Accounts for the downstream stage's one-cycle registered strobe path and one-cycle registered read-data return.

---
 rtl/hpi_pkg.sv | 17 +
 rtl/hpi_txn_sequencer.sv | 137 +++++++++++++
 tb/tb_hpi_txn_sequencer.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/hpi_pkg.sv
// Shared types and HPI register selects for the HPI transaction sequencer.
package hpi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STROBE,
        HOLD,
        RECOVER
    } hpi_seq_state_t;

    localparam logic [1:0] HPI_DATA    = 2'b00;
    localparam logic [1:0] HPI_MAILBOX = 2'b01;
    localparam logic [1:0] HPI_ADDR    = 2'b10;
    localparam logic [1:0] HPI_STATUS  = 2'b11;

endpackage

// File: rtl/hpi_txn_sequencer.sv
// Turns single-word HPI read/write requests into timed cs/rd/wr strobe
// sequences for the downstream registered HPI I/O stage.
module hpi_txn_sequencer
    import hpi_pkg::*;
#(
    parameter int SETUP_CYCLES    = 1,
    parameter int STROBE_CYCLES   = 2,
    parameter int HOLD_CYCLES     = 2,
    parameter int RECOVERY_CYCLES = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_addr,
    input  logic [15:0] req_wdata,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic        busy,
    output logic [1:0]  hpi_address,
    output logic [15:0] hpi_data_out,
    input  logic [15:0] hpi_data_in,
    output logic        hpi_r,
    output logic        hpi_w,
    output logic        hpi_cs
);

    localparam int M01  = (SETUP_CYCLES > STROBE_CYCLES) ? SETUP_CYCLES : STROBE_CYCLES;
    localparam int M23  = (HOLD_CYCLES > RECOVERY_CYCLES) ? HOLD_CYCLES : RECOVERY_CYCLES;
    localparam int MAXP = (M01 > M23) ? M01 : M23;
    localparam int CW   = $clog2(MAXP + 1);

    localparam logic [CW-1:0] LD_SETUP   = CW'(SETUP_CYCLES - 1);
    localparam logic [CW-1:0] LD_STROBE  = CW'(STROBE_CYCLES - 1);
    localparam logic [CW-1:0] LD_HOLD    = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] LD_RECOVER = (RECOVERY_CYCLES > 0) ? CW'(RECOVERY_CYCLES - 1) : '0;
    // Read data is valid two cycles after the last strobe: HOLD index 1.
    localparam logic [CW-1:0] CAP_CNT    = CW'(HOLD_CYCLES - 2);

    hpi_seq_state_t state, nxt_state;
    logic [CW-1:0]  cnt, nxt_cnt;
    logic           lat_write;
    logic           accept;

    assign req_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign accept    = req_valid && req_ready;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= nxt_state;
            cnt   <= nxt_cnt;
        end
    end

    always_comb begin
        nxt_state = state;
        nxt_cnt   = cnt;
        unique case (state)
            IDLE: begin
                if (req_valid) begin
                    nxt_state = SETUP;
                    nxt_cnt   = LD_SETUP;
                end
            end
            SETUP: begin
                if (cnt == '0) begin
                    nxt_state = STROBE;
                    nxt_cnt   = LD_STROBE;
                end else begin
                    nxt_cnt = cnt - 1'b1;
                end
            end
            STROBE: begin
                if (cnt == '0) begin
                    nxt_state = HOLD;
                    nxt_cnt   = LD_HOLD;
                end else begin
                    nxt_cnt = cnt - 1'b1;
                end
            end
            HOLD: begin
                if (cnt == '0) begin
                    nxt_state = (RECOVERY_CYCLES > 0) ? RECOVER : IDLE;
                    nxt_cnt   = (RECOVERY_CYCLES > 0) ? LD_RECOVER : '0;
                end else begin
                    nxt_cnt = cnt - 1'b1;
                end
            end
            RECOVER: begin
                if (cnt == '0) begin
                    nxt_state = IDLE;
                    nxt_cnt   = '0;
                end else begin
                    nxt_cnt = cnt - 1'b1;
                end
            end
            default: begin
                nxt_state = IDLE;
                nxt_cnt   = '0;
            end
        endcase
    end

    // Strobes are registered from the next state so they line up with the
    // state the FSM is actually in.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            lat_write    <= 1'b0;
            hpi_address  <= '0;
            hpi_data_out <= '0;
            hpi_cs       <= 1'b1;
            hpi_r        <= 1'b1;
            hpi_w        <= 1'b1;
            rsp_valid    <= 1'b0;
            rsp_rdata    <= '0;
        end else begin
            if (accept) begin
                lat_write   <= req_write;
                hpi_address <= req_addr;
                if (req_write)
                    hpi_data_out <= req_wdata;
            end
            hpi_cs    <= !(nxt_state == SETUP || nxt_state == STROBE || nxt_state == HOLD);
            hpi_r     <= !(nxt_state == STROBE && !lat_write);
            hpi_w     <= !(nxt_state == STROBE && lat_write);
            rsp_valid <= (state == HOLD) && (cnt == '0);
            if (state == HOLD && cnt == CAP_CNT && !lat_write)
                rsp_rdata <= hpi_data_in;
        end
    end

endmodule

// File: tb/tb_hpi_txn_sequencer.sv
// Directed bench for hpi_txn_sequencer: default-parameter vector table plus
// hand-written back-to-back, reset-abort and parameter-sweep sequences.
module tb_hpi_txn_sequencer;
    import hpi_pkg::*;

    logic        Clk;
    logic        Reset;
    logic        req_valid, req_ready, req_write;
    logic [1:0]  req_addr;
    logic [15:0] req_wdata;
    logic        rsp_valid, busy;
    logic [15:0] rsp_rdata;
    logic [1:0]  hpi_address;
    logic [15:0] hpi_data_out, hpi_data_in;
    logic        hpi_r, hpi_w, hpi_cs;

    logic        sw_valid, sw_ready, sw_write;
    logic [1:0]  sw_addr;
    logic [15:0] sw_wdata;
    logic        sw_rv, sw_busy;
    logic [15:0] sw_rdata;
    logic [1:0]  sw_address;
    logic [15:0] sw_dout, sw_din;
    logic        sw_r, sw_w, sw_cs;

    int checks = 0;
    int errors = 0;

    hpi_txn_sequencer u_dut (
        .Clk(Clk), .Reset(Reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .busy(busy),
        .hpi_address(hpi_address), .hpi_data_out(hpi_data_out),
        .hpi_data_in(hpi_data_in),
        .hpi_r(hpi_r), .hpi_w(hpi_w), .hpi_cs(hpi_cs)
    );

    hpi_txn_sequencer #(
        .SETUP_CYCLES(2), .STROBE_CYCLES(1), .HOLD_CYCLES(3), .RECOVERY_CYCLES(0)
    ) u_sw (
        .Clk(Clk), .Reset(Reset),
        .req_valid(sw_valid), .req_ready(sw_ready), .req_write(sw_write),
        .req_addr(sw_addr), .req_wdata(sw_wdata),
        .rsp_valid(sw_rv), .rsp_rdata(sw_rdata), .busy(sw_busy),
        .hpi_address(sw_address), .hpi_data_out(sw_dout),
        .hpi_data_in(sw_din),
        .hpi_r(sw_r), .hpi_w(sw_w), .hpi_cs(sw_cs)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // I/O stage model: strobe registered once, read data registered once more.
    // Outside the read window the data bus carries a poison value.
    logic io_r_q, sw_r_q;
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            io_r_q      <= 1'b1;
            sw_r_q      <= 1'b1;
            hpi_data_in <= 16'hDEAD;
            sw_din      <= 16'hDEAD;
        end else begin
            io_r_q      <= hpi_r;
            sw_r_q      <= sw_r;
            hpi_data_in <= !io_r_q ? 16'hA5C3 : 16'hDEAD;
            sw_din      <= !sw_r_q ? 16'h5A3C : 16'hDEAD;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ctl = {cs, r, w, rsp_valid, req_ready}
    typedef struct {
        logic        v;
        logic        wr;
        logic [1:0]  a;
        logic [15:0] d;
        logic [4:0]  ctl;
        logic [15:0] rd;
        logic [1:0]  ea;
        logic [15:0] ed;
    } vec_t;

    vec_t tbl[17];

    initial begin
        int acc[$];
        int rcyc[$];
        int wlow, rlow, gap_err, rvcnt, rvk, rdyk, rec, cslow;
        logic [15:0] rvdata;

        // read of STATUS then write of 0x1234 to ADDR, back to back
        tbl[0]  = '{1'b1, 1'b0, HPI_STATUS, 16'h0000, 5'b11101, 16'h0000, 2'd0, 16'h0000};
        tbl[1]  = '{1'b0, 1'b0, HPI_DATA,   16'h0000, 5'b01100, 16'h0000, 2'd3, 16'h0000};
        tbl[2]  = '{1'b0, 1'b0, HPI_DATA,   16'h0000, 5'b00100, 16'h0000, 2'd3, 16'h0000};
        tbl[3]  = '{1'b0, 1'b0, HPI_DATA,   16'h0000, 5'b00100, 16'h0000, 2'd3, 16'h0000};
        tbl[4]  = '{1'b0, 1'b0, HPI_DATA,   16'h0000, 5'b01100, 16'h0000, 2'd3, 16'h0000};
        tbl[5]  = '{1'b0, 1'b0, HPI_DATA,   16'h0000, 5'b01100, 16'h0000, 2'd3, 16'h0000};
        tbl[6]  = '{1'b0, 1'b0, HPI_DATA,   16'h0000, 5'b11110, 16'hA5C3, 2'd3, 16'h0000};
        tbl[7]  = '{1'b0, 1'b0, HPI_DATA,   16'h0000, 5'b11100, 16'hA5C3, 2'd3, 16'h0000};
        tbl[8]  = '{1'b1, 1'b1, HPI_ADDR,   16'h1234, 5'b11101, 16'hA5C3, 2'd3, 16'h0000};
        tbl[9]  = '{1'b0, 1'b0, HPI_DATA,   16'hFFFF, 5'b01100, 16'hA5C3, 2'd2, 16'h1234};
        tbl[10] = '{1'b0, 1'b0, HPI_DATA,   16'hFFFF, 5'b01000, 16'hA5C3, 2'd2, 16'h1234};
        tbl[11] = '{1'b0, 1'b0, HPI_DATA,   16'hFFFF, 5'b01000, 16'hA5C3, 2'd2, 16'h1234};
        tbl[12] = '{1'b0, 1'b0, HPI_DATA,   16'hFFFF, 5'b01100, 16'hA5C3, 2'd2, 16'h1234};
        tbl[13] = '{1'b0, 1'b0, HPI_DATA,   16'hFFFF, 5'b01100, 16'hA5C3, 2'd2, 16'h1234};
        tbl[14] = '{1'b0, 1'b0, HPI_DATA,   16'hFFFF, 5'b11110, 16'hA5C3, 2'd2, 16'h1234};
        tbl[15] = '{1'b0, 1'b0, HPI_DATA,   16'hFFFF, 5'b11100, 16'hA5C3, 2'd2, 16'h1234};
        tbl[16] = '{1'b0, 1'b0, HPI_DATA,   16'hFFFF, 5'b11101, 16'hA5C3, 2'd2, 16'h1234};

        Reset = 1'b0;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        sw_valid = 1'b0; sw_write = 1'b0; sw_addr = '0; sw_wdata = '0;

        // async reset asserted between edges
        #2 Reset = 1'b1;
        #1;
        chk("reset_strobes", {29'd0, hpi_cs, hpi_r, hpi_w}, 32'h7);
        chk("reset_ready", {31'd0, req_ready}, 32'h1);
        chk("reset_rsp_valid", {31'd0, rsp_valid}, 32'h0);
        chk("reset_rdata", {16'd0, rsp_rdata}, 32'h0);
        chk("reset_addr_data", {14'd0, hpi_address, hpi_data_out}, 32'h0);
        @(negedge Clk);
        Reset = 1'b0;

        for (int i = 0; i < 17; i++) begin
            @(negedge Clk);
            req_valid = tbl[i].v;
            req_write = tbl[i].wr;
            req_addr  = tbl[i].a;
            req_wdata = tbl[i].d;
            chk($sformatf("tbl%0d_ctl", i), {27'd0, hpi_cs, hpi_r, hpi_w, rsp_valid, req_ready},
                {27'd0, tbl[i].ctl});
            chk($sformatf("tbl%0d_rdata", i), {16'd0, rsp_rdata}, {16'd0, tbl[i].rd});
            chk($sformatf("tbl%0d_bus", i), {14'd0, hpi_address, hpi_data_out},
                {14'd0, tbl[i].ea, tbl[i].ed});
        end

        // back-to-back: valid held, write then read
        wlow = 0; rlow = 0; gap_err = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge Clk);
            if (k == 0) begin
                req_valid = 1'b1; req_write = 1'b1; req_addr = HPI_DATA; req_wdata = 16'hBEEF;
            end
            if (k == 1) begin
                req_write = 1'b0; req_addr = HPI_MAILBOX;
            end
            if (acc.size() == 2) req_valid = 1'b0;
            if (req_valid && req_ready) acc.push_back(k);
            if (!hpi_w) wlow++;
            if (!hpi_r) rlow++;
            if (k >= 6 && k <= 8 && hpi_cs !== 1'b1) gap_err++;
        end
        req_valid = 1'b0;
        chk("b2b_accepts", acc.size(), 2);
        if (acc.size() == 2) begin
            chk("b2b_first", acc[0], 0);
            chk("b2b_second", acc[1], 8);
        end
        chk("b2b_wlow", wlow, 2);
        chk("b2b_rlow", rlow, 2);
        chk("b2b_cs_gap", gap_err, 0);

        // reset during STROBE of a read
        for (int k = 0; k < 3; k++) begin
            @(negedge Clk);
            if (k == 0) begin
                req_valid = 1'b1; req_write = 1'b0; req_addr = HPI_MAILBOX;
            end
            if (k == 1) req_valid = 1'b0;
        end
        chk("abort_pre_r", {31'd0, hpi_r}, 32'h0);
        #1 Reset = 1'b1;
        #1;
        chk("abort_strobes", {29'd0, hpi_cs, hpi_r, hpi_w}, 32'h7);
        chk("abort_idle", {30'd0, req_ready, busy}, 32'h2);
        chk("abort_rdata", {16'd0, rsp_rdata}, 32'h0);
        @(negedge Clk);
        Reset = 1'b0;
        rvcnt = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge Clk);
            if (rsp_valid) rvcnt++;
        end
        chk("abort_no_rsp", rvcnt, 0);

        rvk = -1;
        rvdata = '0;
        for (int k = 0; k < 12; k++) begin
            @(negedge Clk);
            if (k == 0) begin
                req_valid = 1'b1; req_write = 1'b0; req_addr = HPI_STATUS;
            end
            if (k == 1) req_valid = 1'b0;
            if (rsp_valid && rvk < 0) begin
                rvk = k; rvdata = rsp_rdata;
            end
        end
        chk("post_abort_rv_cycle", rvk, 6);
        chk("post_abort_rdata", {16'd0, rvdata}, 32'h0000A5C3);

        // parameter sweep instance: SETUP=2 STROBE=1 HOLD=3 RECOVERY=0
        rvk = -1; rdyk = -1; rec = 0; cslow = 0; rvdata = '0;
        for (int k = 0; k < 12; k++) begin
            @(negedge Clk);
            if (k == 0) begin
                sw_valid = 1'b1; sw_write = 1'b0; sw_addr = HPI_DATA;
            end
            if (k == 1) sw_valid = 1'b0;
            if (!sw_r) rcyc.push_back(k);
            if (!sw_cs) cslow++;
            if (sw_rv && rvk < 0) begin
                rvk = k; rvdata = sw_rdata;
            end
            if (k > 0 && sw_ready && rdyk < 0) rdyk = k;
            if (u_sw.state == RECOVER) rec++;
        end
        chk("sw_r_count", rcyc.size(), 1);
        if (rcyc.size() == 1) chk("sw_r_cycle", rcyc[0], 3);
        chk("sw_cs_low", cslow, 6);
        chk("sw_rv_cycle", rvk, 7);
        chk("sw_rdata", {16'd0, rvdata}, 32'h00005A3C);
        chk("sw_ready_cycle", rdyk, 7);
        chk("sw_no_recover", rec, 0);
        chk("sw_idle", {13'd0, sw_busy, sw_w, sw_address, sw_dout}, {13'd0, 1'b0, 1'b1, 2'd0, 16'h0});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
